// File: rtl/fret_detector_array.sv
// Samples one pixel per fret channel, applies colour hysteresis, delays decisions by N frames and emits a strum pulse.
// Commit on vsync_strobe, frets/strum/frame_tick update one cycle later; no backpressure. FRET_MAJORITY_EN: 3-pixel 2-of-3 sampling.
module fret_detector_array #(
    parameter int NUM_CH  = 5,
    parameter int DEPTH   = 32,
    parameter int XW      = 11,
    parameter int YW      = 10,
    parameter int STRUM_W = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         vsync_strobe,
    input  logic                         hsync_strobe,
    input  logic                         vde,
    input  logic [23:0]                  rgb,
    input  logic [NUM_CH*(XW+YW)-1:0]    pos,
    input  logic [NUM_CH*24-1:0]         trig_on,
    input  logic [NUM_CH*24-1:0]         trig_off,
    input  logic [$clog2(DEPTH)-1:0]     delay_in,
    input  logic [STRUM_W-1:0]           strum_time,
    output logic [NUM_CH-1:0]            frets,
    output logic                         strum,
    output logic                         frame_tick
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic f_ge(input logic [23:0] a, input logic [23:0] b);
        return (a[23:16] >= b[23:16]) && (a[15:8] >= b[15:8]) && (a[7:0] >= b[7:0]);
    endfunction

    function automatic logic f_le(input logic [23:0] a, input logic [23:0] b);
        return (a[23:16] <= b[23:16]) && (a[15:8] <= b[15:8]) && (a[7:0] <= b[7:0]);
    endfunction

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_vde_d;
    logic          w_cap_en;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_x     <= '0;
            r_y     <= '0;
            r_vde_d <= 1'b0;
        end else begin
            r_vde_d <= vde;
            if (vsync_strobe) begin
                r_x <= '0;
                r_y <= '0;
            end else begin
                if (hsync_strobe)
                    r_x <= '0;
                else if (vde && (r_x != '1))
                    r_x <= r_x + XW'(1);
                if (r_vde_d && !vde && (r_y != '1))
                    r_y <= r_y + YW'(1);
            end
        end
    end

    // Strobe cycles carry stale coordinates, so they never capture.
    assign w_cap_en = vde && !vsync_strobe && !hsync_strobe;

    logic [NUM_CH-1:0] w_press;
    logic [NUM_CH-1:0] w_release;
    logic [NUM_CH-1:0] w_valid;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [XW-1:0] w_px;
        logic [YW-1:0] w_py;
        logic [23:0]   w_on;
        logic [23:0]   w_off;

        assign w_px  = pos[c*(XW+YW) +: XW];
        assign w_py  = pos[c*(XW+YW)+XW +: YW];
        assign w_on  = trig_on[c*24 +: 24];
        assign w_off = trig_off[c*24 +: 24];

`ifdef FRET_MAJORITY_EN
        logic [2:0][23:0] r_pix;
        logic [2:0]       r_seen;
        logic [2:0]       w_hit;
        logic [2:0]       w_p;
        logic [2:0]       w_r;
        logic             w_row;

        assign w_row    = w_cap_en && (r_y == w_py);
        assign w_hit[0] = w_row && (({1'b0, r_x} + (XW+1)'(1)) == {1'b0, w_px});
        assign w_hit[1] = w_row && (r_x == w_px);
        assign w_hit[2] = w_row && ({1'b0, r_x} == ({1'b0, w_px} + (XW+1)'(1)));

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_pix  <= '0;
                r_seen <= '0;
            end else if (vsync_strobe) begin
                r_seen <= '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (w_hit[k] && !r_seen[k]) begin
                        r_pix[k]  <= rgb;
                        r_seen[k] <= 1'b1;
                    end
                end
            end
        end

        // Unseen slots vote neither way, which turns x=0 into a 2-of-2 vote.
        for (genvar k = 0; k < 3; k++) begin : g_vote
            assign w_p[k] = r_seen[k] && f_ge(r_pix[k], w_on);
            assign w_r[k] = r_seen[k] && f_le(r_pix[k], w_off);
        end

        assign w_press[c]   = (w_p[0] & w_p[1]) | (w_p[0] & w_p[2]) | (w_p[1] & w_p[2]);
        assign w_release[c] = (w_r[0] & w_r[1]) | (w_r[0] & w_r[2]) | (w_r[1] & w_r[2]);
        assign w_valid[c]   = r_seen[1] && r_seen[2] && (r_seen[0] || (w_px == '0));
`else
        logic [23:0] r_pix;
        logic        r_seen;
        logic        w_hit;

        assign w_hit = w_cap_en && (r_x == w_px) && (r_y == w_py);

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_pix  <= '0;
                r_seen <= 1'b0;
            end else if (vsync_strobe) begin
                r_seen <= 1'b0;
            end else if (w_hit && !r_seen) begin
                r_pix  <= rgb;
                r_seen <= 1'b1;
            end
        end

        assign w_press[c]   = f_ge(r_pix, w_on);
        assign w_release[c] = f_le(r_pix, w_off);
        assign w_valid[c]   = r_seen;
`endif
    end

    logic [NUM_CH-1:0]             r_state;
    logic [DEPTH-1:0][NUM_CH-1:0]  r_hist;
    logic [AW-1:0]                 r_wp;
    logic [NUM_CH-1:0]             r_frets;
    logic                          r_tick;
    logic [STRUM_W-1:0]            r_cnt;
    logic [NUM_CH-1:0]             w_state_nxt;
    logic [NUM_CH-1:0]             w_frets_nxt;
    logic [AW-1:0]                 w_rd_idx;

    always_comb begin
        w_state_nxt = r_state;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_valid[c]) begin
                if (w_press[c])
                    w_state_nxt[c] = 1'b1;
                else if (w_release[c])
                    w_state_nxt[c] = 1'b0;
            end
        end
    end

    // Zero delay bypasses the history so frets sees the state being written this cycle.
    assign w_rd_idx    = r_wp - delay_in;
    assign w_frets_nxt = (delay_in == '0) ? w_state_nxt : r_hist[w_rd_idx];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= '0;
            r_hist  <= '0;
            r_wp    <= '0;
            r_frets <= '0;
            r_tick  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_tick <= vsync_strobe;
            if (vsync_strobe) begin
                r_state      <= w_state_nxt;
                r_hist[r_wp] <= w_state_nxt;
                r_wp         <= r_wp + AW'(1);
                r_frets      <= w_frets_nxt;
                if ((|(w_frets_nxt & ~r_frets)) && (strum_time != '0))
                    r_cnt <= strum_time;
                else if (r_cnt != '0)
                    r_cnt <= r_cnt - STRUM_W'(1);
            end
        end
    end

    assign frets      = r_frets;
    assign strum      = (r_cnt != '0);
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_fret_detector_array.sv
// Directed, table-driven bench for fret_detector_array.
module tb_fret_detector_array;
    localparam int NUM_CH  = 5;
    localparam int DEPTH   = 32;
    localparam int XW      = 11;
    localparam int YW      = 10;
    localparam int STRUM_W = 4;
    localparam int AW      = $clog2(DEPTH);

    localparam logic [23:0] PH  = 24'h909090;
    localparam logic [23:0] PM  = 24'h606060;
    localparam logic [23:0] PL  = 24'h303030;
    localparam logic [23:0] PX  = 24'h903090;
    localparam logic [23:0] TON = 24'h808080;
    localparam logic [23:0] TOF = 24'h404040;

    logic                       CLK = 1'b0;
    logic                       RST_N;
    logic                       vsync_strobe, hsync_strobe, vde;
    logic [23:0]                rgb;
    logic [NUM_CH*(XW+YW)-1:0]  pos;
    logic [NUM_CH*24-1:0]       trig_on, trig_off;
    logic [AW-1:0]              delay_in;
    logic [STRUM_W-1:0]         strum_time;
    logic [NUM_CH-1:0]          frets;
    logic                       strum, frame_tick;

    fret_detector_array #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .XW(XW), .YW(YW), .STRUM_W(STRUM_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .vsync_strobe(vsync_strobe), .hsync_strobe(hsync_strobe),
        .vde(vde), .rgb(rgb), .pos(pos), .trig_on(trig_on), .trig_off(trig_off),
        .delay_in(delay_in), .strum_time(strum_time), .frets(frets), .strum(strum),
        .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    int          px [NUM_CH];
    int          py [NUM_CH];
    logic [23:0] pl [NUM_CH];
    logic [23:0] pc [NUM_CH];
    logic [23:0] pr [NUM_CH];

    typedef struct {
        logic [NUM_CH-1:0][23:0] p;
        int                      st;
        logic [NUM_CH-1:0]       ef;
        logic                    es;
    } vec_t;

    vec_t tv [14];

    function automatic vec_t mk(input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                                input logic [23:0] a3, input logic [23:0] a4, input int st,
                                input logic [NUM_CH-1:0] ef, input logic es);
        vec_t v;
        v.p[0] = a0; v.p[1] = a1; v.p[2] = a2; v.p[3] = a3; v.p[4] = a4;
        v.st = st; v.ef = ef; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_pix(input int c, input logic [23:0] v);
        pl[c] = v; pc[c] = v; pr[c] = v;
    endtask

    task automatic update_pos();
        for (int c = 0; c < NUM_CH; c++) begin
            pos[c*(XW+YW) +: XW]    = XW'(px[c]);
            pos[c*(XW+YW)+XW +: YW] = YW'(py[c]);
        end
    endtask

    function automatic logic [23:0] pix_at(input int x, input int y);
        logic [23:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (py[c] == y) begin
                if (x == px[c])          v = pc[c];
                else if (x == px[c] - 1) v = pl[c];
                else if (x == px[c] + 1) v = pr[c];
            end
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic h, input logic de, input logic [23:0] d);
        vsync_strobe = v; hsync_strobe = h; vde = de; rgb = d;
        @(negedge CLK);
    endtask

    // Rows 0..50; a row is only as long as the rightmost channel on it needs.
    task automatic send_pixels();
        for (int r = 0; r <= 50; r++) begin
            int len;
            len = 1;
            for (int c = 0; c < NUM_CH; c++)
                if (py[c] == r && px[c] + 2 > len) len = px[c] + 2;
            drive(1'b0, 1'b1, 1'b0, 24'h0);
            for (int x = 0; x < len; x++) drive(1'b0, 1'b0, 1'b1, pix_at(x, r));
            drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic commit(input string nm, input logic [NUM_CH-1:0] ef, input logic es);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        chk({nm, " tick"}, 32'(frame_tick), 32'd1);
        chk({nm, " frets"}, 32'(frets), 32'(ef));
        chk({nm, " strum"}, 32'(strum), 32'(es));
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk({nm, " tick_low"}, 32'(frame_tick), 32'd0);
    endtask

    task automatic frame(input string nm, input logic [NUM_CH-1:0] ef, input logic es);
        send_pixels();
        commit(nm, ef, es);
    endtask

    initial begin
        RST_N = 1'b0;
        vsync_strobe = 1'b0; hsync_strobe = 1'b0; vde = 1'b0; rgb = '0;
        trig_on  = {NUM_CH{TON}};
        trig_off = {NUM_CH{TOF}};
        delay_in = '0; strum_time = '0;
        px[0] = 100; py[0] = 50;
        px[1] = 3;   py[1] = 2;
        px[2] = 6;   py[2] = 2;
        px[3] = 7;   py[3] = 3;
        px[4] = 10;  py[4] = 4;
        for (int c = 0; c < NUM_CH; c++) set_pix(c, PL);
        update_pos();

        tv[0]  = mk(PL,  PL, PL, PL, PL, 2, 5'b00000, 1'b0);
        tv[1]  = mk(PH,  PL, PL, PL, PL, 2, 5'b00001, 1'b1);
        tv[2]  = mk(PM,  PL, PL, PL, PL, 2, 5'b00001, 1'b1);
        tv[3]  = mk(PL,  PL, PL, PL, PL, 2, 5'b00000, 1'b0);
        tv[4]  = mk(TON, PL, PL, PL, PL, 2, 5'b00001, 1'b1);
        tv[5]  = mk(TOF, PL, PL, PL, PL, 2, 5'b00000, 1'b1);
        tv[6]  = mk(PL,  PH, PL, PL, PL, 2, 5'b00010, 1'b1);
        tv[7]  = mk(PL,  PM, PL, PH, PL, 2, 5'b01010, 1'b1);
        tv[8]  = mk(PL,  PM, PL, PM, PL, 2, 5'b01010, 1'b1);
        tv[9]  = mk(PM,  PM, PM, PM, PM, 2, 5'b01010, 1'b0);
        tv[10] = mk(PL,  PX, PL, PL, PL, 2, 5'b00010, 1'b0);
        tv[11] = mk(PL,  PL, PL, PL, PL, 0, 5'b00000, 1'b0);
        tv[12] = mk(PL,  PL, PL, PL, PH, 0, 5'b10000, 1'b0);
        tv[13] = mk(PL,  PL, PL, PL, PL, 0, 5'b00000, 1'b0);

        repeat (3) @(negedge CLK);
        chk("reset frets", 32'(frets), 32'd0);
        chk("reset strum", 32'(strum), 32'd0);
        chk("reset tick", 32'(frame_tick), 32'd0);
        RST_N = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < NUM_CH; c++) set_pix(c, tv[i].p[c]);
            strum_time = STRUM_W'(tv[i].st);
            frame($sformatf("vec%0d", i), tv[i].ef, tv[i].es);
        end

        // Frame delay of 3, then a mid-frame switch back to 0.
        for (int c = 0; c < NUM_CH; c++) set_pix(c, PL);
        for (int i = 0; i < 3; i++) frame($sformatf("dly_pre%0d", i), 5'b00000, 1'b0);
        delay_in = AW'(3);
        set_pix(2, PH);
        frame("dly_k0", 5'b00000, 1'b0);
        for (int c = 0; c < NUM_CH; c++) set_pix(c, PM);
        frame("dly_k1", 5'b00000, 1'b0);
        frame("dly_k2", 5'b00000, 1'b0);
        frame("dly_k3", 5'b00100, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 24'h0);
        delay_in = '0;
        repeat (5) drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("dly_change no glitch", 32'(frets), 32'b00100);
        set_pix(2, PL);
        frame("dly_now0", 5'b00000, 1'b0);

        // Channel moved off-screen holds its state.
        set_pix(4, PH);
        frame("offscr_set", 5'b10000, 1'b0);
        py[4] = 1023; update_pos();
        set_pix(4, PL);
        for (int i = 0; i < 4; i++) frame($sformatf("offscr%0d", i), 5'b10000, 1'b0);
        py[4] = 4; update_pos();
        set_pix(4, PM);

        // Combined vsync+hsync with a bright pixel must not be captured at (0,0).
        px[1] = 0; py[1] = 0; update_pos();
        set_pix(1, PL);
        frame("both_pre", 5'b10000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, PH);
        chk("both_strobe tick", 32'(frame_tick), 32'd1);
        chk("both_strobe frets", 32'(frets), 32'b10000);
        drive(1'b0, 1'b0, 1'b1, PL);
        drive(1'b0, 1'b0, 1'b1, PL);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        commit("both_nocap", 5'b10000, 1'b0);
        set_pix(1, PH);
        frame("both_origin", 5'b10010, 1'b0);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        set_pix(0, PH); set_pix(1, PL); set_pix(2, PH); set_pix(3, PL); set_pix(4, PL);
        strum_time = STRUM_W'(2);
        frame("rst_pre", 5'b00101, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, PH);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst frets", 32'(frets), 32'd0);
        chk("midrst strum", 32'(strum), 32'd0);
        chk("midrst tick", 32'(frame_tick), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        vde = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        for (int c = 0; c < NUM_CH; c++) set_pix(c, 24'h000000);
        frame("post_rst_black", 5'b00000, 1'b0);

`ifdef FRET_MAJORITY_EN
        strum_time = '0;
        px[0] = 10; py[0] = 1; update_pos();
        pl[0] = PH; pc[0] = PM; pr[0] = PH;
        frame("maj_2of3", 5'b00001, 1'b0);
        px[0] = 0; update_pos();
        pc[0] = PL; pr[0] = PM;
        frame("maj_x0_disagree", 5'b00001, 1'b0);
        pc[0] = PL; pr[0] = PL;
        frame("maj_x0_agree", 5'b00000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
